// File: rtl/coproc_dispatcher.sv
// Host-side job sequencer for the coprocessor index interface: fetches the job config word,
// walks every (row, col) tile in row-major order and owns the single memory port.
module coproc_dispatcher #(
  parameter int unsigned size            = 3,
  parameter int unsigned cell_width      = 32,
  parameter int unsigned index_width     = 8,
  parameter int unsigned width           = cell_width * size,
  parameter int unsigned memory_size_log = 8,
  parameter int unsigned config_address  = 0
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_start,
  output logic                       out_grant,
  output logic [index_width-1:0]     out_row_index,
  output logic [index_width-1:0]     out_col_index,
  output logic                       out_index_ready,
  output logic [index_width-1:0]     out_mu,
  output logic [cell_width-1:0]      out_config,
  input  logic                       in_index_ack,
  input  logic                       in_result_ready,
  input  logic                       in_cp_mem_read_en,
  input  logic                       in_cp_mem_write_en,
  input  logic [memory_size_log-1:0] in_cp_mem_address,
  input  logic [width-1:0]           in_cp_mem_data,
  input  logic [width-1:0]           in_mem_data,
  output logic [memory_size_log-1:0] out_mem_address,
  output logic [width-1:0]           out_mem_data,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic                       out_busy,
  output logic                       out_done,
  output logic [2*index_width-1:0]   out_tile_count,
  output logic                       out_protocol_err
);

  localparam int unsigned CntW = 2 * index_width;

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StCheck, StIssue, StRun, StRelease, StDone
  } state_e;

  state_e state_q, state_d;

  logic [index_width-1:0]     row_q, row_d, col_q, col_d;
  logic                       ack_q, ack_d;
  logic [cell_width-1:0]      cfg_q, cfg_d;
  logic [index_width-1:0]     mu_q, mu_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       grant_q, grant_d;
  logic                       irdy_q, irdy_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [memory_size_log-1:0] maddr_q, maddr_d;
  logic [width-1:0]           mdata_q, mdata_d;
  logic                       mre_q, mre_d;
  logic                       mwe_q, mwe_d;

  logic [index_width-1:0] lambda, gamma, last_row, last_col;
  logic                   last_tile, fwd_state;
  logic                   unused_mem_hi;

  assign lambda        = cfg_q[index_width-1:0];
  assign gamma         = cfg_q[2*index_width-1:index_width];
  assign last_row      = lambda - index_width'(1);
  assign last_col      = gamma - index_width'(1);
  assign last_tile     = (row_q == last_row) && (col_q == last_col);
  assign fwd_state     = (state_q == StIssue) || (state_q == StRun) || (state_q == StRelease);
  assign unused_mem_hi = ^in_mem_data[width-1:cell_width];

  // State register
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_start) state_d = StFetch;
      StFetch:   state_d = StLoad;
      StLoad:    state_d = StCheck;
      StCheck:   state_d = ((lambda == '0) || (gamma == '0)) ? StDone : StIssue;
      StIssue:   state_d = StRun;
      StRun:     if (in_result_ready) state_d = StRelease;
      StRelease: state_d = last_tile ? StDone : StIssue;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Job datapath: tile walk, ack tracking, config latch, counters
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ack_d = ack_q;
    cfg_d = cfg_q;
    mu_d  = mu_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          cnt_d = '0;
          err_d = 1'b0;
        end
      end
      StLoad: begin
        cfg_d = in_mem_data[cell_width-1:0];
        mu_d  = in_mem_data[3*index_width-1:2*index_width];
      end
      StCheck: begin
        row_d = '0;
        col_d = '0;
        ack_d = 1'b0;
      end
      StRun: begin
        if (in_result_ready) begin
          cnt_d = cnt_q + CntW'(1);
          // An ack arriving together with result_ready still counts for this tile.
          if (!(ack_q || in_index_ack)) err_d = 1'b1;
          ack_d = 1'b0;
        end else if (in_index_ack) begin
          ack_d = 1'b1;
        end
      end
      StRelease: begin
        if (!last_tile) begin
          if (col_q == last_col) begin
            col_d = '0;
            row_d = row_q + index_width'(1);
          end else begin
            col_d = col_q + index_width'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, computed from the state being entered
  always_comb begin
    grant_d = (state_d == StIssue) || (state_d == StRun) || (state_d == StRelease);
    irdy_d  = (state_d == StIssue) || (state_d == StRun);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    mre_d   = 1'b0;
    mwe_d   = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    if (state_d == StFetch) begin
      mre_d   = 1'b1;
      maddr_d = memory_size_log'(config_address);
    end else if (fwd_state && (state_d != StDone)) begin
      if (in_cp_mem_write_en) begin
        mwe_d   = 1'b1;
        maddr_d = in_cp_mem_address;
        mdata_d = in_cp_mem_data;
      end else if (in_cp_mem_read_en) begin
        mre_d   = 1'b1;
        maddr_d = in_cp_mem_address;
        mdata_d = '0;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      row_q   <= '0;
      col_q   <= '0;
      ack_q   <= 1'b0;
      cfg_q   <= '0;
      mu_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      grant_q <= 1'b0;
      irdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      mre_q   <= 1'b0;
      mwe_q   <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      ack_q   <= ack_d;
      cfg_q   <= cfg_d;
      mu_q    <= mu_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      irdy_q  <= irdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mre_q   <= mre_d;
      mwe_q   <= mwe_d;
    end
  end

  assign out_grant        = grant_q;
  assign out_row_index    = row_q;
  assign out_col_index    = col_q;
  assign out_index_ready  = irdy_q;
  assign out_mu           = mu_q;
  assign out_config       = cfg_q;
  assign out_mem_address  = maddr_q;
  assign out_mem_data     = mdata_q;
  assign out_mem_read_en  = mre_q;
  assign out_mem_write_en = mwe_q;
  assign out_busy         = busy_q;
  assign out_done         = done_q;
  assign out_tile_count   = cnt_q;
  assign out_protocol_err = err_q;

endmodule
